// File: rtl/seed_host_sequencer.sv
// Host-side job sequencer for the SEED128 core: key cycle, text cycle, wait for done, hold result.
// Optional WAIT timeout is enabled by defining SEED_TIMEOUT_EN (adds o_fTimeout).
module seed_host_sequencer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_fStart,
    input  logic         i_fDec,
    input  logic [127:0] i_Key,
    input  logic [127:0] i_Text,
    output logic         o_fReady,
    output logic [128:0] o_CoreData,
    input  logic [127:0] i_CoreText,
    input  logic         i_CoreDone,
    output logic [127:0] o_Result,
    output logic         o_fValid,
    input  logic         i_fAck,
`ifdef SEED_TIMEOUT_EN
    output logic         o_fTimeout,
`endif
    output logic         o_fBusy,
    output logic [7:0]   o_Latency
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SENDKEY = 3'd1,
        SENDTXT = 3'd2,
        WAIT    = 3'd3,
        HOLD    = 3'd4
    } state_t;

`ifdef SEED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam logic [7:0] EXPIRY = 8'(TIMEOUT_CYC - 1);

    state_t        state_q;
    state_t        state_d;
    logic [127:0]  key_q;
    logic [127:0]  text_q;
    logic          dec_q;
    logic [7:0]    wait_cnt_q;
    logic [127:0]  result_q;
    logic [7:0]    latency_q;
    logic          expired;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Constant-false when the timeout feature is compiled out, so WAIT waits forever.
    assign expired = TMO_EN && (wait_cnt_q == EXPIRY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_fStart) state_d = SENDKEY;
            SENDKEY: state_d = SENDTXT;
            SENDTXT: state_d = WAIT;
            WAIT:    if (i_CoreDone || expired) state_d = HOLD;
            HOLD:    if (i_fAck) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_CoreData = '0;
        case (state_q)
            SENDKEY: o_CoreData = {1'b1, key_q};
            SENDTXT: o_CoreData = {dec_q, text_q};
            default: o_CoreData = '0;
        endcase
    end

    assign o_fReady  = (state_q == IDLE);
    assign o_fBusy   = (state_q != IDLE);
    assign o_fValid  = (state_q == HOLD);
    assign o_Result  = result_q;
    assign o_Latency = latency_q;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            text_q     <= '0;
            dec_q      <= 1'b0;
            wait_cnt_q <= '0;
            result_q   <= '0;
            latency_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && i_fStart) begin
                key_q  <= i_Key;
                text_q <= i_Text;
                dec_q  <= i_fDec;
            end
            if (state_q == SENDTXT) begin
                wait_cnt_q <= '0;
            end else if (state_q == WAIT) begin
                wait_cnt_q <= sat_inc(wait_cnt_q);
            end
            // Done takes priority over expiry when both land in the same cycle.
            if (state_q == WAIT) begin
                if (i_CoreDone) begin
                    result_q  <= i_CoreText;
                    latency_q <= wait_cnt_q;
                end else if (expired) begin
                    result_q  <= '0;
                    latency_q <= wait_cnt_q;
                end
            end
        end
    end

`ifdef SEED_TIMEOUT_EN
    logic timeout_q;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            timeout_q <= 1'b0;
        end else if (state_q == WAIT && !i_CoreDone && expired) begin
            timeout_q <= 1'b1;
        end else if (state_q == HOLD && i_fAck) begin
            timeout_q <= 1'b0;
        end
    end

    assign o_fTimeout = timeout_q;
`else
`endif

endmodule

// File: tb/tb_seed_host_sequencer.sv
// Scoreboard bench for seed_host_sequencer: a stub core answers each job, expected results are queued at start.
module tb_seed_host_sequencer;

    localparam int TMO = 8;
    localparam logic [127:0] PT = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] CT = 128'h5EBAC6E0054E166819AFF1CC6D346CDB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         dec;
    logic [127:0] key;
    logic [127:0] text;
    logic         ready;
    logic [128:0] core_data;
    logic [127:0] core_text;
    logic         core_done;
    logic [127:0] result;
    logic         valid;
    logic         ack;
    logic         busy;
    logic [7:0]   latency;
`ifdef SEED_TIMEOUT_EN
    logic         timeout;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_res_q[$];
    logic [7:0]   exp_lat_q[$];

    seed_host_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_fStart   (start),
        .i_fDec     (dec),
        .i_Key      (key),
        .i_Text     (text),
        .o_fReady   (ready),
        .o_CoreData (core_data),
        .i_CoreText (core_text),
        .i_CoreDone (core_done),
        .o_Result   (result),
        .o_fValid   (valid),
        .i_fAck     (ack),
`ifdef SEED_TIMEOUT_EN
        .o_fTimeout (timeout),
`endif
        .o_fBusy    (busy),
        .o_Latency  (latency)
    );

    always #5 clk = ~clk;

    // Called at a negedge in IDLE; returns at the negedge of the first WAIT cycle.
    task automatic start_job(input logic [127:0] k, input logic [127:0] t, input logic d,
                             input bit spur, input string tag);
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b expected 1", tag, ready); end
        start = 1'b1; key = k; text = t; dec = d;
        @(negedge clk);
        start = 1'b0; key = ~k; text = ~t; dec = ~d;
        n_checks++;
        if (core_data !== {1'b1, k}) begin n_fail++; $display("FAIL %s_keycyc: got %h expected %h", tag, core_data, {1'b1, k}); end
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL %s_busy_ready: got %b expected 0", tag, ready); end
        @(negedge clk);
        n_checks++;
        if (core_data !== {d, t}) begin n_fail++; $display("FAIL %s_txtcyc: got %h expected %h", tag, core_data, {d, t}); end
        if (spur) begin core_done = 1'b1; core_text = ~t; end
        @(negedge clk);
        core_done = 1'b0;
    endtask

    task automatic drive_done(input int lat, input logic [127:0] t);
        repeat (lat) @(negedge clk);
        core_done = 1'b1; core_text = t;
        @(negedge clk);
        core_done = 1'b0; core_text = $urandom();
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", valid); end
        n_checks++; if (core_data !== 129'h0) begin n_fail++; $display("FAIL rst_coredata: got %h expected 0", core_data); end
        n_checks++; if (result !== 128'h0) begin n_fail++; $display("FAIL rst_result: got %h expected 0", result); end
        n_checks++; if (latency !== 8'h0) begin n_fail++; $display("FAIL rst_latency: got %0d expected 0", latency); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_encrypt();
        bit ok; logic [127:0] er; logic [7:0] el;
        exp_res_q.push_back(CT); exp_lat_q.push_back(8'd3);
        start_job('0, PT, 1'b0, 1'b0, "enc");
        drive_done(3, CT);
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL enc_valid: got 0 expected 1"); end
        er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
        n_checks++; if (result !== er) begin n_fail++; $display("FAIL enc_result: got %h expected %h", result, er); end
        n_checks++; if (latency !== el) begin n_fail++; $display("FAIL enc_latency: got %0d expected %0d", latency, el); end
        repeat (3) @(negedge clk);
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL enc_hold: got %b expected 1", valid); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL enc_ack_valid: got %b expected 0", valid); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL enc_ack_ready: got %b expected 1", ready); end
        n_checks++; if (result !== er) begin n_fail++; $display("FAIL enc_keep: got %h expected %h", result, er); end
    endtask

    task automatic test_decrypt();
        bit ok; logic [127:0] er; logic [7:0] el;
        exp_res_q.push_back(PT); exp_lat_q.push_back(8'd0);
        start_job('0, CT, 1'b1, 1'b0, "dec");
        drive_done(0, PT);
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL dec_valid: got 0 expected 1"); end
        er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
        n_checks++; if (result !== er) begin n_fail++; $display("FAIL dec_result: got %h expected %h", result, er); end
        n_checks++; if (latency !== el) begin n_fail++; $display("FAIL dec_latency: got %0d expected %0d", latency, el); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok; logic [127:0] er; logic [7:0] el;
        logic [127:0] r1 = 128'hA5A5_0123_4567_89AB_CDEF_FEDC_BA98_5A5A;
        logic [127:0] r2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        exp_res_q.push_back(r1); exp_lat_q.push_back(8'd1);
        start_job(128'hDEAD_BEEF, 128'h0BAD_F00D, 1'b0, 1'b0, "bp");
        drive_done(1, r1);
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_valid: got 0 expected 1"); end
        er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
        n_checks++; if (latency !== el) begin n_fail++; $display("FAIL bp_latency: got %0d expected %0d", latency, el); end
        for (int i = 0; i < 20; i++) begin
            start = (i == 10); key = 128'hFF; text = 128'hEE;
            n_checks++;
            if (valid !== 1'b1 || result !== er) begin
                n_fail++; $display("FAIL bp_stable: cycle %0d valid %b result %h expected %h", i, valid, result, er);
            end
            if (i == 10) begin
                n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0", ready); end
            end
            @(negedge clk);
        end
        ack = 1'b1; start = 1'b1;
        @(negedge clk);
        ack = 1'b0; start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_ackstart_busy: got %b expected 0", busy); end
        n_checks++; if (core_data !== 129'h0) begin n_fail++; $display("FAIL bp_ackstart_bus: got %h expected 0", core_data); end
        exp_res_q.push_back(r2); exp_lat_q.push_back(8'd0);
        start_job(128'h42, 128'h24, 1'b1, 1'b0, "bp2");
        drive_done(0, r2);
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp2_valid: got 0 expected 1"); end
        er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
        n_checks++; if (result !== er) begin n_fail++; $display("FAIL bp2_result: got %h expected %h", result, er); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_spurious_done();
        bit ok; logic [127:0] er; logic [7:0] el; logic [127:0] prev;
        logic [127:0] r3 = 128'hC0FF_EE00_1234_5678_9ABC_DEF0_0F0F_F0F0;
        prev = result;
        core_done = 1'b1; core_text = 128'hBADBAD;
        repeat (2) @(negedge clk);
        core_done = 1'b0;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL spur_idle_valid: got %b expected 0", valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL spur_idle_busy: got %b expected 0", busy); end
        n_checks++; if (result !== prev) begin n_fail++; $display("FAIL spur_idle_result: got %h expected %h", result, prev); end
        exp_res_q.push_back(r3); exp_lat_q.push_back(8'd2);
        start_job(128'h77, 128'h99, 1'b0, 1'b1, "spur");
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL spur_txt_valid: got %b expected 0", valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL spur_txt_busy: got %b expected 1", busy); end
        drive_done(2, r3);
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL spur_valid: got 0 expected 1"); end
        er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
        n_checks++; if (result !== er) begin n_fail++; $display("FAIL spur_result: got %h expected %h", result, er); end
        n_checks++; if (latency !== el) begin n_fail++; $display("FAIL spur_latency: got %0d expected %0d", latency, el); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        start_job(128'h5, 128'h6, 1'b0, 1'b0, "rmw");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmw_busy: got %b expected 0", busy); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rmw_ready: got %b expected 1", ready); end
        n_checks++; if (core_data !== 129'h0) begin n_fail++; $display("FAIL rmw_bus: got %h expected 0", core_data); end
        n_checks++; if (result !== 128'h0) begin n_fail++; $display("FAIL rmw_result: got %h expected 0", result); end
        n_checks++; if (latency !== 8'h0) begin n_fail++; $display("FAIL rmw_latency: got %0d expected 0", latency); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

`ifndef SEED_TIMEOUT_EN
    task automatic test_latency_saturation();
        bit ok; logic [127:0] er; logic [7:0] el;
        exp_res_q.push_back(128'h5A); exp_lat_q.push_back(8'd255);
        start_job(128'h1, 128'h2, 1'b0, 1'b0, "sat");
        drive_done(300, 128'h5A);
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_valid: got 0 expected 1"); end
        er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
        n_checks++; if (result !== er) begin n_fail++; $display("FAIL sat_result: got %h expected %h", result, er); end
        n_checks++; if (latency !== el) begin n_fail++; $display("FAIL sat_latency: got %0d expected %0d", latency, el); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask
`else
    task automatic test_timeout();
        bit ok; logic [127:0] er; logic [7:0] el;
        exp_res_q.push_back(128'h0); exp_lat_q.push_back(8'(TMO - 1));
        start_job(128'h3, 128'h4, 1'b0, 1'b0, "tmo");
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_valid: got 0 expected 1"); end
        er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b expected 1", timeout); end
        n_checks++; if (result !== er) begin n_fail++; $display("FAIL tmo_result: got %h expected %h", result, er); end
        n_checks++; if (latency !== el) begin n_fail++; $display("FAIL tmo_latency: got %0d expected %0d", latency, el); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b expected 0", timeout); end
        exp_res_q.push_back(128'hABC); exp_lat_q.push_back(8'(TMO - 1));
        start_job(128'h3, 128'h4, 1'b0, 1'b0, "tmo2");
        drive_done(TMO - 1, 128'hABC);
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo2_valid: got 0 expected 1"); end
        er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo2_flag: got %b expected 0", timeout); end
        n_checks++; if (result !== er) begin n_fail++; $display("FAIL tmo2_result: got %h expected %h", result, er); end
        n_checks++; if (latency !== el) begin n_fail++; $display("FAIL tmo2_latency: got %0d expected %0d", latency, el); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; dec = 1'b0; key = '0; text = '0;
        core_text = '0; core_done = 1'b0; ack = 1'b0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_back_to_back();
        test_spurious_done();
        test_reset_mid_wait();
`ifndef SEED_TIMEOUT_EN
        test_latency_saturation();
`else
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
